qed_dup_encoder: RTL and testbench
==================================

QED_DUP_ENCODER -- requirements
Module: qed_dup_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, duplicate-FIFO entries (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ifu_qed_instruction  input  32  original ORBIS32 instruction from fetch.
REQ-005 SHALL have port ena  input  1  fetch slot valid this cycle.
REQ-006 SHALL have port exec_dup  input  1  0 = original mode, 1 = duplicate (replay) mode.
REQ-007 SHALL have port qed_ifu_instruction  output  32  instruction issued to the pipeline, registered.
REQ-008 SHALL have port vld_out  output  1  qed_ifu_instruction is valid, registered.
REQ-009 SHALL have ports fifo_empty and fifo_full  output  1 each  occupancy flags, combinational from the count.

Function
REQ-010 SHALL classify the input with the same fields and rules as the team's ORBIS32 QED decoder: opcode6 = [31:26]; load = opcode6 in {0x21,0x22,0x23,0x24,0x25,0x26} with [15:14]=00; store = {0x35,0x36,0x37}; alureg = 0x38; aluimm = {0x27,0x29,0x2A,0x2B,0x2C,0x2E}.
REQ-011 SHALL remap each register field r to {1'b1, r[3:0]}.
REQ-012 SHALL encode alureg by remapping rD [25:21], rA [20:16], and rB [15:11], with all other bits copied.
REQ-013 SHALL encode aluimm by remapping rD and rA, with the immediate copied.
REQ-014 SHALL encode load by remapping rD and rA and setting bit 14 (immediate upper-half memory).
REQ-015 SHALL encode store by remapping rA [20:16] and rB [15:11] and setting bit 24 (split-immediate bit 14).
REQ-016 SHALL encode any other instruction as l.nop 0x15000000.
REQ-017 SHALL, when ena=1 and exec_dup=0, register the input unchanged onto qed_ifu_instruction with vld_out=1 on the next cycle.
REQ-018 SHALL, in the same cycle as REQ-017, push the encoded duplicate into the FIFO if not full.
REQ-019 SHALL drop the push when full and leave FIFO contents and pointers unchanged.
REQ-020 SHALL, when ena=1 and exec_dup=1 and the FIFO is not empty, pop the head entry onto qed_ifu_instruction with vld_out=1 on the next cycle.
REQ-021 SHALL, when ena=1 and exec_dup=1 and the FIFO is empty, output 0x15000000 with vld_out=0 and leave the pointers unchanged.
REQ-022 SHALL never push while exec_dup=1, so no simultaneous push and pop can occur.
REQ-023 SHALL, when ena=0, hold qed_ifu_instruction, drive vld_out=0, and leave the FIFO unchanged.
REQ-024 SHALL wrap read and write pointers modulo DEPTH and keep a count of 0..DEPTH; fifo_empty = (count==0), fifo_full = (count==DEPTH).
REQ-025 SHALL preserve FIFO order: duplicates replay in exactly the order the originals were issued.
REQ-026 SHALL not affect FIFO contents when exec_dup toggles; replay resumes at the current head.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set qed_ifu_instruction=0x15000000, vld_out=0, pointers=0, count=0 (fifo_empty=1, fifo_full=0).
REQ-028 SHALL give rst priority over ena; a reset mid-replay discards all buffered entries.

Configuration
REQ-029 SHALL, with QED_DUP_OVERFLOW_FLAG_EN defined, add output port dup_overflow (1 bit, reset 0) that sets sticky on any dropped push (REQ-019) and clears only on rst.
REQ-030 SHALL, without QED_DUP_OVERFLOW_FLAG_EN defined, omit the dup_overflow port; dropped pushes are silent and all other behaviour is identical.

Verification
REQ-031 SHALL cover: reset, then ena=1, exec_dup=0, input 0xE0611000 -> next cycle out 0xE0611000, vld_out=1; then exec_dup=1 -> out 0xE2719000, vld_out=1, fifo_empty=1.
REQ-032 SHALL cover: original 0x84820008 (l.lwz r4,8(r2)) -> replay 0x86924008.
REQ-033 SHALL cover: originals 0xE0611000 then 0x84820008, then replay -> order 0xE2719000, 0x86924008, then 0x15000000 with vld_out=0.
REQ-034 SHALL cover: DEPTH=16, push 17 originals -> fifo_full=1 after 16; dup_overflow=1 when the macro is defined; replay yields exactly 16 entries.
REQ-035 SHALL cover: push 5, replay 2, assert rst, then replay -> out 0x15000000, vld_out=0, fifo_empty=1.
REQ-036 SHALL cover: original 0x15000000 (non-class) -> replay 0x15000000 with vld_out=1, since a valid NOP duplicate was pushed.

Source files
------------

// File: rtl/qed_dup_encoder.sv
// QED duplicate encoder: passes originals through and queues register-remapped duplicates for replay.
// Optional sticky overflow flag port enabled by defining QED_DUP_OVERFLOW_FLAG_EN.
module qed_dup_encoder #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ifu_qed_instruction,
  input  logic        ena,
  input  logic        exec_dup,
  output logic [31:0] qed_ifu_instruction,
  output logic        vld_out,
  output logic        fifo_empty,
  output logic        fifo_full
`ifdef QED_DUP_OVERFLOW_FLAG_EN
  ,
  output logic        dup_overflow
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h1500_0000;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [5:0]    opcode6;
  logic          is_load, is_store, is_alureg, is_aluimm;
  logic [31:0]   dup_instr;
  logic          push, pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));

  assign opcode6   = ifu_qed_instruction[31:26];
  assign is_load   = (opcode6 inside {6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26}) &&
                     (ifu_qed_instruction[15:14] == 2'b00);
  assign is_store  = opcode6 inside {6'h35, 6'h36, 6'h37};
  assign is_alureg = (opcode6 == 6'h38);
  assign is_aluimm = opcode6 inside {6'h27, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2E};

  // Each register field keeps its low four bits and moves into the upper half of the register file.
  always_comb begin
    dup_instr = NOP;
    if (is_alureg) begin
      dup_instr        = ifu_qed_instruction;
      dup_instr[25:21] = {1'b1, ifu_qed_instruction[24:21]};
      dup_instr[20:16] = {1'b1, ifu_qed_instruction[19:16]};
      dup_instr[15:11] = {1'b1, ifu_qed_instruction[14:11]};
    end else if (is_aluimm) begin
      dup_instr        = ifu_qed_instruction;
      dup_instr[25:21] = {1'b1, ifu_qed_instruction[24:21]};
      dup_instr[20:16] = {1'b1, ifu_qed_instruction[19:16]};
    end else if (is_load) begin
      dup_instr        = ifu_qed_instruction;
      dup_instr[25:21] = {1'b1, ifu_qed_instruction[24:21]};
      dup_instr[20:16] = {1'b1, ifu_qed_instruction[19:16]};
      dup_instr[14]    = 1'b1;
    end else if (is_store) begin
      dup_instr        = ifu_qed_instruction;
      dup_instr[20:16] = {1'b1, ifu_qed_instruction[19:16]};
      dup_instr[15:11] = {1'b1, ifu_qed_instruction[14:11]};
      dup_instr[24]    = 1'b1;
    end
  end

  assign push = !rst && ena && !exec_dup && !fifo_full;
  assign pop  = !rst && ena &&  exec_dup && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dup_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qed_ifu_instruction <= NOP;
      vld_out             <= 1'b0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
    end else if (ena) begin
      if (!exec_dup) begin
        qed_ifu_instruction <= ifu_qed_instruction;
        vld_out             <= 1'b1;
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count + CW'(1);
        end
      end else if (pop) begin
        qed_ifu_instruction <= mem[rd_ptr];
        vld_out             <= 1'b1;
        rd_ptr              <= rd_ptr + AW'(1);
        count               <= count - CW'(1);
      end else begin
        qed_ifu_instruction <= NOP;
        vld_out             <= 1'b0;
      end
    end else begin
      vld_out <= 1'b0;
    end
  end

`ifdef QED_DUP_OVERFLOW_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)
      dup_overflow <= 1'b0;
    else if (ena && !exec_dup && fifo_full)
      dup_overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_qed_dup_encoder.sv
// Directed self-checking bench for qed_dup_encoder (DEPTH=16).
module tb_qed_dup_encoder;

  localparam logic [31:0] NOP = 32'h1500_0000;

  logic        clk = 1'b0;
  logic        rst, ena, exec_dup;
  logic [31:0] ifu_qed_instruction;
  logic [31:0] qed_ifu_instruction;
  logic        vld_out, fifo_empty, fifo_full;
`ifdef QED_DUP_OVERFLOW_FLAG_EN
  logic        dup_overflow;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  qed_dup_encoder #(.DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .ifu_qed_instruction(ifu_qed_instruction),
    .ena(ena),
    .exec_dup(exec_dup),
    .qed_ifu_instruction(qed_ifu_instruction),
    .vld_out(vld_out),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full)
`ifdef QED_DUP_OVERFLOW_FLAG_EN
    ,
    .dup_overflow(dup_overflow)
`endif
  );

  task automatic step(input logic r, input logic e, input logic d, input logic [31:0] ins);
    rst = r; ena = e; exec_dup = d; ifu_qed_instruction = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    vectors += 4;
    if (qed_ifu_instruction !== NOP) begin miscompares++; $display("FAIL reset_instr got %h want %h", qed_ifu_instruction, NOP); end
    if (vld_out !== 1'b0) begin miscompares++; $display("FAIL reset_vld got %b want 0", vld_out); end
    if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
    if (fifo_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", fifo_full); end
`ifdef QED_DUP_OVERFLOW_FLAG_EN
    vectors++;
    if (dup_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", dup_overflow); end
`endif
  endtask

  // Push one original, check pass-through, then replay and check the duplicate.
  task automatic test_one(input string name, input logic [31:0] orig, input logic [31:0] exp_dup);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, orig);
    vectors += 3;
    if (qed_ifu_instruction !== orig) begin miscompares++; $display("FAIL %s_orig got %h want %h", name, qed_ifu_instruction, orig); end
    if (vld_out !== 1'b1) begin miscompares++; $display("FAIL %s_orig_vld got %b want 1", name, vld_out); end
    if (fifo_empty !== 1'b0) begin miscompares++; $display("FAIL %s_orig_empty got %b want 0", name, fifo_empty); end
    step(1'b0, 1'b1, 1'b1, 32'h0);
    vectors += 3;
    if (qed_ifu_instruction !== exp_dup) begin miscompares++; $display("FAIL %s_dup got %h want %h", name, qed_ifu_instruction, exp_dup); end
    if (vld_out !== 1'b1) begin miscompares++; $display("FAIL %s_dup_vld got %b want 1", name, vld_out); end
    if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL %s_dup_empty got %b want 1", name, fifo_empty); end
  endtask

  task automatic test_classes();
    test_one("alureg", 32'hE061_1000, 32'hE271_9000);
    test_one("load",   32'h8482_0008, 32'h8692_4008);
    test_one("store",  32'hD401_1800, 32'hD511_9800);
    test_one("aluimm", 32'h9C41_0005, 32'h9E51_0005);
    test_one("nop",    32'h1500_0000, 32'h1500_0000);
    test_one("load_hi_imm", 32'h8482_C008, 32'h1500_0000);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3];
    logic        expv [3];
    exp[0] = 32'hE271_9000; expv[0] = 1'b1;
    exp[1] = 32'h8692_4008; expv[1] = 1'b1;
    exp[2] = NOP;           expv[2] = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'hE061_1000);
    step(1'b0, 1'b1, 1'b0, 32'h8482_0008);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h0);
      vectors += 2;
      if (qed_ifu_instruction !== exp[i]) begin miscompares++; $display("FAIL order%0d got %h want %h", i, qed_ifu_instruction, exp[i]); end
      if (vld_out !== expv[i]) begin miscompares++; $display("FAIL order%0d_vld got %b want %b", i, vld_out, expv[i]); end
    end
  endtask

  task automatic test_full();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'hE000_0000 | i);
      vectors++;
      if (fifo_full !== (i >= 15)) begin miscompares++; $display("FAIL full_after%0d got %b want %b", i + 1, fifo_full, (i >= 15)); end
`ifdef QED_DUP_OVERFLOW_FLAG_EN
      vectors++;
      if (dup_overflow !== (i == 16)) begin miscompares++; $display("FAIL ovf_after%0d got %b want %b", i + 1, dup_overflow, (i == 16)); end
`endif
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h0);
      vectors += 2;
      if (qed_ifu_instruction !== (32'hE210_8000 | i)) begin miscompares++; $display("FAIL full_replay%0d got %h want %h", i, qed_ifu_instruction, 32'hE210_8000 | i); end
      if (vld_out !== 1'b1) begin miscompares++; $display("FAIL full_replay%0d_vld got %b want 1", i, vld_out); end
    end
    step(1'b0, 1'b1, 1'b1, 32'h0);
    vectors += 3;
    if (qed_ifu_instruction !== NOP) begin miscompares++; $display("FAIL full_extra got %h want %h", qed_ifu_instruction, NOP); end
    if (vld_out !== 1'b0) begin miscompares++; $display("FAIL full_extra_vld got %b want 0", vld_out); end
    if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL full_extra_empty got %b want 1", fifo_empty); end
`ifdef QED_DUP_OVERFLOW_FLAG_EN
    vectors++;
    if (dup_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", dup_overflow); end
`endif
  endtask

  task automatic test_reset_mid_replay();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 32'hE000_0000 | i);
    step(1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0);
    vectors++;
    if (qed_ifu_instruction !== 32'hE210_8001) begin miscompares++; $display("FAIL midrst_pre got %h want %h", qed_ifu_instruction, 32'hE210_8001); end
    step(1'b1, 1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0);
    vectors += 3;
    if (qed_ifu_instruction !== NOP) begin miscompares++; $display("FAIL midrst_instr got %h want %h", qed_ifu_instruction, NOP); end
    if (vld_out !== 1'b0) begin miscompares++; $display("FAIL midrst_vld got %b want 0", vld_out); end
    if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL midrst_empty got %b want 1", fifo_empty); end
  endtask

  task automatic test_hold();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h9C41_0005);
    step(1'b0, 1'b0, 1'b1, 32'hE061_1000);
    vectors += 3;
    if (qed_ifu_instruction !== 32'h9C41_0005) begin miscompares++; $display("FAIL hold_instr got %h want %h", qed_ifu_instruction, 32'h9C41_0005); end
    if (vld_out !== 1'b0) begin miscompares++; $display("FAIL hold_vld got %b want 0", vld_out); end
    if (fifo_empty !== 1'b0) begin miscompares++; $display("FAIL hold_empty got %b want 0", fifo_empty); end
    step(1'b0, 1'b0, 1'b0, 32'h8482_0008);
    step(1'b0, 1'b1, 1'b1, 32'h0);
    vectors += 3;
    if (qed_ifu_instruction !== 32'h9E51_0005) begin miscompares++; $display("FAIL hold_replay got %h want %h", qed_ifu_instruction, 32'h9E51_0005); end
    if (vld_out !== 1'b1) begin miscompares++; $display("FAIL hold_replay_vld got %b want 1", vld_out); end
    if (fifo_empty !== 1'b1) begin miscompares++; $display("FAIL hold_replay_empty got %b want 1", fifo_empty); end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; exec_dup = 1'b0; ifu_qed_instruction = '0;
    #1;
    test_reset();
    test_classes();
    test_back_to_back();
    test_full();
    test_reset_mid_replay();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
